// File: rtl/padd_pkg.sv
// padd_pkg: shared constants, stage-count helper and per-stage control record for pipelined_adder
package padd_pkg;
    localparam int WIDTH_DEF = 64;
    localparam int SEG_DEF = 16;
    function automatic int nseg(input int width, input int seg);
        return width / seg;
    endfunction
    typedef struct packed {
        logic valid;
        logic carry;
        logic zero;
    } padd_stage_t;
endpackage

// File: rtl/padd_stage.sv
// padd_stage: one SEG-bit segment add plus its stage register, holding while en is low
module padd_stage
    import padd_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SEG = SEG_DEF,
    parameter bit SAT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  padd_stage_t      prev,
    input  logic [WIDTH-1:0] prev_data,
    input  logic [WIDTH-1:0] prev_rem,
    output padd_stage_t      cur,
    output logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] rem,
    output logic             ovf
);
    logic [SEG:0] s;
    logic [WIDTH-1:0] data_raw, data_nx, rem_nx;
    logic ovf_nx, zero_raw, zero_nx;
    assign s = {1'b0, prev_data[SEG-1:0]} + {1'b0, prev_rem[SEG-1:0]} + {{SEG{1'b0}}, prev.carry};
    assign ovf_nx = (prev_data[SEG-1] == prev_rem[SEG-1]) && (s[SEG-1] != prev_data[SEG-1]);
    assign zero_raw = prev.zero && (s[SEG-1:0] == '0);
    // data rotates right: consumed A segments leave the bottom, sum segments enter the top
    if (WIDTH == SEG) begin : g_one
        assign data_raw = s[SEG-1:0];
        assign rem_nx = '0;
    end else begin : g_rot
        assign data_raw = {s[SEG-1:0], prev_data[WIDTH-1:SEG]};
        assign rem_nx = {{SEG{1'b0}}, prev_rem[WIDTH-1:SEG]};
    end
    if (SAT) begin : g_sat
        assign data_nx = ovf_nx ? {prev_data[SEG-1], {(WIDTH-1){~prev_data[SEG-1]}}} : data_raw;
        assign zero_nx = zero_raw && !ovf_nx;
    end else begin : g_wrap
        assign data_nx = data_raw;
        assign zero_nx = zero_raw;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= '0;
            data <= '0;
            rem <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            cur <= '{valid: prev.valid, carry: s[SEG], zero: zero_nx};
            data <= data_nx;
            rem <= rem_nx;
            ovf <= ovf_nx;
        end
    end
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/sub split into WIDTH/SEG registered segments with valid/ready flow.
// Define PADD_SAT_EN to saturate the result on signed overflow.
module pipelined_adder
    import padd_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SEG = SEG_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);
    localparam int NSEG = nseg(WIDTH, SEG);
`ifdef PADD_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif
    padd_stage_t st [NSEG+1];
    logic [WIDTH-1:0] data [NSEG+1];
    logic [WIDTH-1:0] rem [NSEG+1];
    logic ovf [NSEG];
    logic en;
    assign en = ~(out_valid & ~out_ready);
    assign in_ready = en;
    assign st[0] = '{valid: in_valid, carry: sub ^ cin, zero: 1'b1};
    assign data[0] = a;
    assign rem[0] = sub ? ~b : b;
    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        padd_stage #(.WIDTH(WIDTH), .SEG(SEG), .SAT(SAT_EN && (k == NSEG - 1))) u_stage (
            .clk(clk),
            .rst(rst),
            .en(en),
            .prev(st[k]),
            .prev_data(data[k]),
            .prev_rem(rem[k]),
            .cur(st[k+1]),
            .data(data[k+1]),
            .rem(rem[k+1]),
            .ovf(ovf[k])
        );
    end
    assign out_valid = st[NSEG].valid;
    assign out_sum = data[NSEG];
    assign out_cout = st[NSEG].carry;
    assign out_zero = st[NSEG].zero;
    assign out_ovf = ovf[NSEG-1];
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed and randomized checks of pipelined_adder against a wide-arithmetic model
module tb_pipelined_adder;
    localparam int W = 64;
    localparam int LAT = 4;
    localparam logic signed [65:0] MAXS = 66'sh0_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [65:0] MINS = -MAXS - 66'sd1;
    typedef struct packed {
        logic [W-1:0] sum;
        logic cout;
        logic ovf;
        logic zero;
    } res_t;

    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b1;
    logic [W-1:0] a = '0, b = '0;
    logic in_ready, out_valid, out_cout, out_ovf, out_zero;
    logic [W-1:0] out_sum;
    int checks = 0, errors = 0;

    pipelined_adder #(.WIDTH(W), .SEG(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc, input logic ms);
        res_t r;
        logic [64:0] u;
        logic signed [65:0] sv;
        if (ms) begin
            u = {1'b0, ma} - {1'b0, mb} - {64'd0, mc};
            r.cout = ~u[64];
            sv = $signed({{2{ma[63]}}, ma}) - $signed({{2{mb[63]}}, mb}) - $signed({65'd0, mc});
        end else begin
            u = {1'b0, ma} + {1'b0, mb} + {64'd0, mc};
            r.cout = u[64];
            sv = $signed({{2{ma[63]}}, ma}) + $signed({{2{mb[63]}}, mb}) + $signed({65'd0, mc});
        end
        r.sum = u[63:0];
        r.ovf = (sv > MAXS) || (sv < MINS);
`ifdef PADD_SAT_EN
        if (r.ovf) r.sum = sv[65] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`endif
        r.zero = (r.sum == '0);
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0: return '1;
            1: return 64'h7FFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return '0;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    task automatic run_single(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input logic ts,
                              output res_t r, output int lat);
        @(negedge clk);
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        r = '{out_sum, out_cout, out_ovf, out_zero};
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        checks++; if (out_sum !== '0) begin errors++; $display("FAIL reset out_sum: got %h want 0", out_sum); end
        checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL reset out_cout: got %b want 0", out_cout); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset out_ovf: got %b want 0", out_ovf); end
        checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL reset out_zero: got %b want 0", out_zero); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [8];
        logic [W-1:0] vb [8];
        logic [1:0] vcs [8];
        res_t ve [8];
        res_t r;
        int lat;
        logic [W-1:0] pos_ovf, neg_ovf;
`ifdef PADD_SAT_EN
        pos_ovf = 64'h7FFF_FFFF_FFFF_FFFF;
        neg_ovf = 64'h8000_0000_0000_0000;
`else
        pos_ovf = 64'h8000_0000_0000_0000;
        neg_ovf = 64'h7FFF_FFFF_FFFF_FFFF;
`endif
        va[0] = 64'h0000_0000_0000_FFFF; vb[0] = 64'd1; vcs[0] = 2'b00; ve[0] = '{64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0};
        va[1] = '1;                      vb[1] = 64'd0; vcs[1] = 2'b10; ve[1] = '{64'd0, 1'b1, 1'b0, 1'b1};
        va[2] = 64'd5;                   vb[2] = 64'd7; vcs[2] = 2'b01; ve[2] = '{64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
        va[3] = 64'h7FFF_FFFF_FFFF_FFFF; vb[3] = 64'd1; vcs[3] = 2'b00; ve[3] = '{pos_ovf, 1'b0, 1'b1, 1'b0};
        va[4] = '1;                      vb[4] = 64'd1; vcs[4] = 2'b00; ve[4] = '{64'd0, 1'b1, 1'b0, 1'b1};
        va[5] = 64'h8000_0000_0000_0000; vb[5] = 64'd1; vcs[5] = 2'b01; ve[5] = '{neg_ovf, 1'b1, 1'b1, 1'b0};
        va[6] = 64'd0;                   vb[6] = 64'd0; vcs[6] = 2'b11; ve[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
        va[7] = 64'h1234_5678_9ABC_DEF0; vb[7] = 64'h1234_5678_9ABC_DEF0; vcs[7] = 2'b01; ve[7] = '{64'd0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            run_single(va[i], vb[i], vcs[i][1], vcs[i][0], r, lat);
            checks++; if (lat != LAT) begin errors++; $display("FAIL directed%0d latency: got %0d want %0d", i, lat, LAT); end
            checks++; if (r.sum !== ve[i].sum) begin errors++; $display("FAIL directed%0d sum: got %h want %h", i, r.sum, ve[i].sum); end
            checks++; if (r.cout !== ve[i].cout) begin errors++; $display("FAIL directed%0d cout: got %b want %b", i, r.cout, ve[i].cout); end
            checks++; if (r.ovf !== ve[i].ovf) begin errors++; $display("FAIL directed%0d ovf: got %b want %b", i, r.ovf, ve[i].ovf); end
            checks++; if (r.zero !== ve[i].zero) begin errors++; $display("FAIL directed%0d zero: got %b want %b", i, r.zero, ve[i].zero); end
        end
    endtask

    task automatic test_back_to_back();
        res_t q[$];
        res_t e, got;
        int sent = 0, recv = 0, cyc = 0;
        logic [W-1:0] na, nb;
        logic nc, ns;
        na = rnd_op(); nb = rnd_op(); nc = 1'($urandom_range(0, 1)); ns = 1'($urandom_range(0, 1));
        while (recv < 20 && cyc < 600) begin
            @(negedge clk);
            cyc++;
            out_ready = 1'($urandom_range(0, 1));
            in_valid = (sent < 20);
            a = na; b = nb; cin = nc; sub = ns;
            #1;
            checks++;
            if (in_ready !== ~(out_valid & ~out_ready)) begin
                errors++; $display("FAIL b2b in_ready cyc %0d: got %b want %b", cyc, in_ready, ~(out_valid & ~out_ready));
            end
            if (out_valid && out_ready) begin
                got = '{out_sum, out_cout, out_ovf, out_zero};
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL b2b extra result: got %h with nothing outstanding", out_sum);
                end else begin
                    e = q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL b2b result %0d: got sum %h c%b o%b z%b want sum %h c%b o%b z%b",
                                 recv, got.sum, got.cout, got.ovf, got.zero, e.sum, e.cout, e.ovf, e.zero);
                    end
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(na, nb, nc, ns));
                sent++;
                na = rnd_op(); nb = rnd_op(); nc = 1'($urandom_range(0, 1)); ns = 1'($urandom_range(0, 1));
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (sent != 20 || recv != 20 || q.size() != 0) begin
            errors++; $display("FAIL b2b count: sent %0d received %0d outstanding %0d want 20/20/0", sent, recv, q.size());
        end
    endtask

    task automatic test_reset_inflight();
        res_t r, e;
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = rnd_op(); b = rnd_op(); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush out_valid: got %b want 0", out_valid); end
        checks++; if ({out_sum, out_cout, out_ovf, out_zero} !== '0) begin
            errors++; $display("FAIL flush outputs: got sum %h c%b o%b z%b want all 0", out_sum, out_cout, out_ovf, out_zero);
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush in_ready: got %b want 1", in_ready); end
        e = model(64'h0123_4567_89AB_CDEF, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b1);
        run_single(64'h0123_4567_89AB_CDEF, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b1, r, lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL flush latency: got %0d want %0d", lat, LAT); end
        checks++; if (r !== e) begin
            errors++; $display("FAIL flush result: got sum %h c%b o%b z%b want sum %h c%b o%b z%b",
                               r.sum, r.cout, r.ovf, r.zero, e.sum, e.cout, e.ovf, e.zero);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
